// File: rtl/rv_configs.sv
// rv_configs: shared RV32I constants and the rv_imem loader state encodings.
package rv_configs;
   localparam int XLEN = 32;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;
   localparam logic [2:0] RV_IMEM_ST_IDLE = 3'd0;
   localparam logic [2:0] RV_IMEM_ST_HDR  = 3'd1;
   localparam logic [2:0] RV_IMEM_ST_DATA = 3'd2;
   localparam logic [2:0] RV_IMEM_ST_CSUM = 3'd3;
   localparam logic [2:0] RV_IMEM_ST_DONE = 3'd4;
   localparam logic [2:0] RV_IMEM_ST_ERR  = 3'd5;
`ifdef RV_IMEM_CHECKSUM_EN
   localparam bit RV_IMEM_CHECKSUM_DEF = 1'b1;
`else
   localparam bit RV_IMEM_CHECKSUM_DEF = 1'b0;
`endif
endpackage

// File: rtl/rv_adder.sv
// rv_adder: plain W-bit wrap-around adder; only built when RV_IMEM_CHECKSUM_EN is defined, since the loader checksum is its sole user.
`ifdef RV_IMEM_CHECKSUM_EN
module rv_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum
);
   assign o_sum = i_a + i_b;
endmodule
`endif

// File: rtl/rv_imem_byte_packer.sv
// rv_imem_byte_packer: gathers four little-endian bytes into a word, pulsing o_word_valid on the 4th byte.
module rv_imem_byte_packer (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);
   logic [1:0]  r_lane;
   logic [23:0] r_sh;
   // Shift accepted bytes in from the top so the first byte ends up in the low lane.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_lane <= 2'd0;
         r_sh   <= 24'd0;
      end else if (i_clr) begin
         r_lane <= 2'd0;
      end else if (i_en) begin
         r_lane <= r_lane + 2'd1;
         r_sh   <= {i_byte, r_sh[23:8]};
      end
   end
   assign o_word       = {i_byte, r_sh};
   assign o_word_valid = i_en && (r_lane == 2'd3);
endmodule

// File: rtl/rv_imem.sv
// rv_imem: combinational instruction fetch port plus byte-serial program loader; RV_IMEM_CHECKSUM_EN adds a trailing 32-bit checksum.
module rv_imem
   import rv_configs::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            i_imem_clk,
   input  logic            i_imem_rstn,
   input  logic [XLEN-1:0] i_imem_ra,
   output logic [31:0]     o_imem_rd,
   input  logic            i_imem_ld_start,
   input  logic            i_imem_ld_valid,
   input  logic [7:0]      i_imem_ld_byte,
   output logic            o_imem_ld_ready,
   output logic            o_imem_ld_busy,
   output logic            o_imem_ld_done,
   output logic            o_imem_ld_err
);
   logic [2:0]  r_state;
   logic [AW:0] r_n;
   logic [AW:0] r_wcnt;
   logic [31:0] r_mem [DEPTH];
   logic [31:0] w_word;
   logic        w_word_valid;
   logic        w_xfer;
   logic        w_start;
   logic        w_last;
   logic        w_n_bad;
   logic        w_wr;
`ifdef RV_IMEM_CHECKSUM_EN
   logic [31:0] r_sum;
   logic [31:0] w_sum;
   rv_adder #(.W(32)) u_csum (.i_a(r_sum), .i_b(w_word), .o_sum(w_sum));
`endif
   assign o_imem_ld_ready = (r_state == RV_IMEM_ST_HDR) || (r_state == RV_IMEM_ST_DATA) || (r_state == RV_IMEM_ST_CSUM);
   assign o_imem_ld_busy  = (r_state != RV_IMEM_ST_IDLE);
   assign o_imem_ld_done  = (r_state == RV_IMEM_ST_DONE);
   assign o_imem_ld_err   = (r_state == RV_IMEM_ST_ERR);
   assign w_xfer  = i_imem_ld_valid && o_imem_ld_ready;
   assign w_start = i_imem_ld_start && ((r_state == RV_IMEM_ST_IDLE) || (r_state == RV_IMEM_ST_ERR));
   assign w_last  = (r_wcnt == r_n - 1'b1);
   assign w_n_bad = (w_word == 32'd0) || (w_word > 32'(DEPTH));
   assign w_wr    = (r_state == RV_IMEM_ST_DATA) && w_word_valid;
   assign o_imem_rd = (i_imem_ra >= XLEN'(4 * DEPTH)) ? RV_NOP : r_mem[i_imem_ra[AW+1:2]];
   rv_imem_byte_packer u_pack (
      .i_clk        (i_imem_clk),
      .i_rstn       (i_imem_rstn),
      .i_clr        (w_start),
      .i_en         (w_xfer),
      .i_byte       (i_imem_ld_byte),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );
   // Loader FSM: each completed word from the packer advances header, data or checksum handling.
   always_ff @(posedge i_imem_clk or negedge i_imem_rstn) begin
      if (!i_imem_rstn) begin
         r_state <= RV_IMEM_ST_IDLE;
         r_n     <= '0;
         r_wcnt  <= '0;
`ifdef RV_IMEM_CHECKSUM_EN
         r_sum   <= 32'd0;
`endif
      end else if (w_start) begin
         r_state <= RV_IMEM_ST_HDR;
         r_wcnt  <= '0;
`ifdef RV_IMEM_CHECKSUM_EN
         r_sum   <= 32'd0;
`endif
      end else if (r_state == RV_IMEM_ST_DONE) begin
         r_state <= RV_IMEM_ST_IDLE;
      end else if (w_word_valid) begin
         case (r_state)
            RV_IMEM_ST_HDR: begin
               r_state <= w_n_bad ? RV_IMEM_ST_ERR : RV_IMEM_ST_DATA;
               r_n     <= w_word[AW:0];
            end
            RV_IMEM_ST_DATA: begin
               r_wcnt <= r_wcnt + 1'b1;
`ifdef RV_IMEM_CHECKSUM_EN
               r_sum   <= w_sum;
               r_state <= w_last ? RV_IMEM_ST_CSUM : RV_IMEM_ST_DATA;
`else
               r_state <= w_last ? RV_IMEM_ST_DONE : RV_IMEM_ST_DATA;
`endif
            end
`ifdef RV_IMEM_CHECKSUM_EN
            RV_IMEM_ST_CSUM: r_state <= (w_word == r_sum) ? RV_IMEM_ST_DONE : RV_IMEM_ST_ERR;
`endif
            default: ;
         endcase
      end
   end
   // Instruction array is never reset; a word lands on the edge that accepts its 4th byte.
   always_ff @(posedge i_imem_clk) begin
      if (w_wr) r_mem[r_wcnt[AW-1:0]] <= w_word;
   end
endmodule

// File: tb/tb_rv_imem.sv
// tb_rv_imem: directed self-checking bench for rv_imem (fetch table plus loader sequences).
module tb_rv_imem;
   localparam int DEPTH = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct {
      logic [31:0] ra;
      logic [31:0] exp;
   } fv_t;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] ra = 32'd0;
   logic [31:0] rd;
   logic        start = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        ready, busy, done, err;
   logic [31:0] ld_w [16];
   fv_t         fv [9];
   int          n_chk = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          done_snap;
   rv_imem #(.DEPTH(DEPTH)) dut (
      .i_imem_clk      (clk),
      .i_imem_rstn     (rstn),
      .i_imem_ra       (ra),
      .o_imem_rd       (rd),
      .i_imem_ld_start (start),
      .i_imem_ld_valid (valid),
      .i_imem_ld_byte  (byte_in),
      .o_imem_ld_ready (ready),
      .o_imem_ld_busy  (busy),
      .o_imem_ld_done  (done),
      .o_imem_ld_err   (err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (done === 1'b1) done_cnt++;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b);
      valid = 1'b1;
      byte_in = b;
      step();
      valid = 1'b0;
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
   endtask
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   task automatic fetch_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      ra = a;
      #1;
      chk(name, rd, exp);
   endtask
   task automatic load(input logic [31:0] n_hdr, input int nw, input bit bad_sum);
      logic [31:0] sum;
      sum = 32'd0;
      pulse_start();
      send_word(n_hdr);
      for (int i = 0; i < nw; i++) begin
         send_word(ld_w[i]);
         sum = sum + ld_w[i];
      end
`ifdef RV_IMEM_CHECKSUM_EN
      send_word(bad_sum ? 32'd0 : sum);
`else
      if (bad_sum) sum = 32'd0;
`endif
   endtask
   initial begin
      fv[0] = '{32'h0,         32'h0010_0093};
      fv[1] = '{32'h1,         32'h0010_0093};
      fv[2] = '{32'h3,         32'h0010_0093};
      fv[3] = '{32'h4,         32'h0020_0113};
      fv[4] = '{32'h7,         32'h0020_0113};
      fv[5] = '{32'h8,         32'hCAFE_F00D};
      fv[6] = '{32'h40,        NOP};
      fv[7] = '{32'h41,        NOP};
      fv[8] = '{32'hFFFF_FFFC, NOP};
      step();
      step();
      chk("rst_ready", ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      fetch_chk("rst_oor_nop", 32'h40, NOP);
      rstn = 1'b1;
      step();
      ld_w[0] = 32'hAAAA_5555;
      ld_w[1] = 32'h1234_5678;
      ld_w[2] = 32'hCAFE_F00D;
      load(32'd3, 3, 1'b0);
      chk("a_done", done, 1'b1);
      chk("a_busy", busy, 1'b1);
      chk("a_ready", ready, 1'b0);
      step();
      chk("a_done_fall", done, 1'b0);
      chk("a_busy_fall", busy, 1'b0);
      chk("a_done_cnt", done_cnt, 1);
      ld_w[0] = 32'h0010_0093;
      ld_w[1] = 32'h0020_0113;
      load(32'd2, 2, 1'b0);
      chk("b_done", done, 1'b1);
      step();
      chk("b_busy_fall", busy, 1'b0);
      chk("b_done_cnt", done_cnt, 2);
      for (int i = 0; i < 9; i++) fetch_chk($sformatf("fetch_%0d", i), fv[i].ra, fv[i].exp);
      step();
      pulse_start();
      chk("n0_busy", busy, 1'b1);
      chk("n0_ready", ready, 1'b1);
      send_word(32'd0);
      chk("n0_err", err, 1'b1);
      chk("n0_err_busy", busy, 1'b1);
      chk("n0_err_ready", ready, 1'b0);
      step();
      step();
      step();
      chk("n0_err_sticky", err, 1'b1);
      pulse_start();
      chk("restart_clr_err", err, 1'b0);
      chk("restart_ready", ready, 1'b1);
      send_word(32'(DEPTH + 1));
      chk("nbig_err", err, 1'b1);
      chk("nbig_busy", busy, 1'b1);
      for (int i = 0; i < 16; i++) ld_w[i] = 32'h1000 + 32'(i);
      load(32'(DEPTH), DEPTH, 1'b0);
      chk("full_done", done, 1'b1);
      chk("full_err", err, 1'b0);
      step();
      fetch_chk("full_last", 32'h3C, 32'h0000_100F);
      fetch_chk("full_first", 32'h0, 32'h0000_1000);
`ifdef RV_IMEM_CHECKSUM_EN
      done_snap = done_cnt;
      ld_w[0] = 32'h1;
      ld_w[1] = 32'h2;
      load(32'd2, 2, 1'b1);
      chk("csum_bad_err", err, 1'b1);
      step();
      chk("csum_bad_nodone", done_cnt, done_snap);
      fetch_chk("csum_bad_w0", 32'h0, 32'h1);
      fetch_chk("csum_bad_w1", 32'h4, 32'h2);
`endif
      pulse_start();
      send_word(32'd2);
      ld_w[0] = 32'h0010_0093;
      ld_w[1] = 32'h0020_0113;
      for (int w = 0; w < 2; w++)
         for (int b = 0; b < 4; b++) begin
            byte_in = 8'hFF;
            start = (w == 1 && b == 0);
            step();
            start = 1'b0;
            send(ld_w[w][8*b +: 8]);
         end
`ifdef RV_IMEM_CHECKSUM_EN
      send_word(32'h0030_01A6);
`endif
      chk("tog_done", done, 1'b1);
      step();
      fetch_chk("tog_w0", 32'h0, 32'h0010_0093);
      fetch_chk("tog_w1", 32'h4, 32'h0020_0113);
      fetch_chk("tog_w2_kept", 32'h8, 32'h0000_1002);
      step();
      pulse_start();
      send_word(32'd2);
      send_word(32'h5566_7788);
      fetch_chk("mid_w0_visible", 32'h0, 32'h5566_7788);
      send(8'h11);
      send(8'h22);
      #1 rstn = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_ready", ready, 1'b0);
      fetch_chk("arst_w0_kept", 32'h0, 32'h5566_7788);
      fetch_chk("arst_w1_old", 32'h4, 32'h0020_0113);
      #1 rstn = 1'b1;
      step();
      chk("arst_idle", busy, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
